program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Byte-stream program loader sitting directly upstream of the pipelined processor core.
- Receives a framed program image over a valid/ready byte interface and drives the core's instruction-memory write port (instr_we, instr_feed, instr_write_address) one word at a time.
- Holds the core in reset until the image has been received and its checksum verified, then supplies init_pc and releases the core.

Parameters:
- ADDR_W, 10, instruction-memory word address width (matches the core's instr_write_address and init_pc).
- MAX_WORDS, 1024, largest accepted word count (must be <= 2**ADDR_W).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_valid  input  1  byte on rx_data is valid.
- rx_data  input  8  incoming byte.
- rx_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle request to reload a new image; honoured only in RUN or ERROR.
- instr_we  output  1  instruction-memory write strobe, one cycle per word.
- instr_feed  output  32  word to write.
- instr_write_address  output  ADDR_W  word address to write.
- init_pc  output  ADDR_W  start PC for the core.
- proc_rst  output  1  reset to the core; high while loading.
- load_done  output  1  image loaded and verified; core running.
- load_error  output  2  00 none, 01 bad count, 10 bad pc, 11 checksum mismatch.

Behaviour:
- Reset values: rx_ready=0, instr_we=0, instr_feed=0, instr_write_address=0, init_pc=0, proc_rst=1, load_done=0, load_error=00. State is IDLE. All of these take effect immediately on rst assertion, including mid-load.
- Byte transfer: a byte is accepted on a rising edge when rx_valid & rx_ready. rx_ready is a registered level: 1 in CNT_HI, CNT_LO, PC_HI, PC_LO, DATA and CKSUM; 0 in IDLE, RUN and ERROR. rx_ready rises one cycle after reset deassertion (IDLE moves to CNT_HI unconditionally). rx_data is ignored when rx_valid=0.
- Frame layout: count[15:8], count[7:0], pc[15:8], pc[7:0], then count words of 4 bytes each (most-significant byte first), then 1 checksum byte.
- Checksum: XOR of every byte from count[15:8] through the last data byte. The accumulator clears on entry to CNT_HI.
- State transitions:
  - CNT_HI -> CNT_LO -> PC_HI -> PC_LO, each on an accepted byte.
  - CNT_LO: if count == 0 or count > MAX_WORDS, go to ERROR with code 01 after the byte is accepted.
  - PC_LO: if pc >= count, go to ERROR with code 10. Otherwise latch init_pc = pc[ADDR_W-1:0] and go to DATA.
  - DATA: a 2-bit byte index assembles the word. On acceptance of byte index 3, assert instr_we for exactly the next cycle with instr_feed = the assembled word and instr_write_address = the word index. The word index starts at 0 and increments after each write. After word count-1 is written, go to CKSUM.
  - CKSUM: on an accepted byte, if the byte equals the accumulator go to RUN, otherwise go to ERROR with code 11.
  - RUN: proc_rst=0 and load_done=1, both registered, so the core leaves reset the cycle after the checksum byte is accepted.
  - ERROR: proc_rst stays 1 and load_done=0. load_error holds its code until reload or rst.
- reload in RUN or ERROR: next cycle proc_rst=1, load_done=0, load_error=00, word index=0, state moves to CNT_HI. reload in any other state is ignored.
- The last instr_we pulse always precedes the proc_rst falling edge by at least 1 cycle.
- init_pc is stable from PC_LO acceptance until the next reload or rst.
- The word index never wraps: the count check guarantees index < MAX_WORDS.
- Throughput: one byte per cycle sustained, with no back-pressure inside the receiving states.

Decomposition:
- Shared package loader_pkg holds:
  - State enum: IDLE, CNT_HI, CNT_LO, PC_HI, PC_LO, DATA, CKSUM, RUN, ERROR.
  - Error code constants: ERR_NONE, ERR_COUNT, ERR_PC, ERR_CKSUM.
  - Header length constant: 4 bytes.
- One sub-module, word_assembler: a byte-index counter plus a 32-bit shift register that emits word_valid together with the word. The FSM, checksum and address counter stay in program_loader.

Test Plan:
- Nominal load. Bytes 00 02 00 01 20 01 00 05 00 00 00 00 27, all with rx_valid held high.
  - Two instr_we pulses: (addr 0, 0x20010005) and (addr 1, 0x00000000).
  - init_pc=1, load_error=00.
  - proc_rst falls and load_done rises exactly 1 cycle after the 0x27 byte is accepted.
- Checksum mismatch. Same frame with a final byte of 0x26.
  - Both writes still occur.
  - proc_rst stays 1, load_error=11, rx_ready=0.
- Bad header cases.
  - count 0x0000 gives load_error=01 with no further bytes accepted.
  - count 0x0401 gives load_error=01.
  - count 2 with pc 0x0002 gives load_error=10 and no instr_we pulse.
- Gapped input. The nominal frame sent with rx_valid low for 3 cycles between every byte produces identical writes and an identical result. No byte is double-counted during the gaps.
- Reset mid-load. Assert rst after the 6th byte.
  - proc_rst=1, instr_we=0, load_done=0 immediately.
  - A full nominal frame sent afterwards loads correctly starting at addr 0.
- Reload. From RUN, pulse reload, then send count 1, pc 0, word 0xAABBCCDD, checksum 0x01^0x00^0xAA^0xBB^0xCC^0xDD = 0x01.
  - proc_rst rises the cycle after reload.
  - One write: (addr 0, 0xAABBCCDD).
  - The core is released again.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, error codes,
// frame header length.
package loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        PC_HI,
        PC_LO,
        DATA,
        CKSUM,
        RUN,
        ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_COUNT = 2'b01;
    localparam logic [1:0] ERR_PC    = 2'b10;
    localparam logic [1:0] ERR_CKSUM = 2'b11;

    localparam int unsigned HDR_BYTES = 4;

    function automatic logic is_rx_state(input state_e s);
        return s inside {CNT_HI, CNT_LO, PC_HI, PC_LO, DATA, CKSUM};
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs four consecutive bytes (MSB first) into a 32-bit word and flags
// word_valid for one cycle once the fourth byte has been shifted in.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_idx,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] shift_q, shift_d;
    logic        valid_q, valid_d;

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        if (clear) begin
            idx_d = '0;
        end else if (byte_valid) begin
            shift_d = {shift_q[23:0], byte_data};
            idx_d   = idx_q + 2'd1;
            valid_d = (idx_q == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    assign byte_idx   = idx_q;
    assign word_valid = valid_q;
    assign word       = shift_q;

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream program loader: writes the image into instruction memory,
// verifies the XOR checksum, then hands init_pc to the core and releases it.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              instr_we,
    output logic [31:0]       instr_feed,
    output logic [ADDR_W-1:0] instr_write_address,
    output logic [ADDR_W-1:0] init_pc,
    output logic              proc_rst,
    output logic              load_done,
    output logic [1:0]        load_error
);

    state_e            state_q, state_d;
    logic              rx_ready_q, rx_ready_d;
    logic              proc_rst_q, proc_rst_d;
    logic              load_done_q, load_done_d;
    logic [1:0]        err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        pc_hi_q, pc_hi_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] init_pc_q, init_pc_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;

    logic        accept;
    logic        asm_clear;
    logic [1:0]  byte_idx;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] cnt_new;
    logic [15:0] pc_new;

    assign accept  = rx_valid & rx_ready_q;
    assign cnt_new = {cnt_q[15:8], rx_data};
    assign pc_new  = {pc_hi_q, rx_data};

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (accept && (state_q == DATA)),
        .byte_data  (rx_data),
        .byte_idx   (byte_idx),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_hi_d    = pc_hi_q;
        err_d      = err_q;
        init_pc_d  = init_pc_q;
        asm_clear  = 1'b0;
        csum_d     = csum_q;
        word_idx_d = word_idx_q;

        // Word index advances during the write pulse, so it is current for the next word.
        if (word_valid) begin
            word_idx_d = word_idx_q + 1'b1;
        end
        if (accept && (state_q inside {CNT_HI, CNT_LO, PC_HI, PC_LO, DATA})) begin
            csum_d = csum_q ^ rx_data;
        end

        unique case (state_q)
            IDLE: begin
                state_d   = CNT_HI;
                csum_d    = '0;
                asm_clear = 1'b1;
            end
            CNT_HI: if (accept) begin
                cnt_d[15:8] = rx_data;
                state_d     = CNT_LO;
            end
            CNT_LO: if (accept) begin
                cnt_d[7:0] = rx_data;
                if ((cnt_new == 16'd0) || (32'(cnt_new) > MAX_WORDS)) begin
                    state_d = ERROR;
                    err_d   = ERR_COUNT;
                end else begin
                    state_d = PC_HI;
                end
            end
            PC_HI: if (accept) begin
                pc_hi_d = rx_data;
                state_d = PC_LO;
            end
            PC_LO: if (accept) begin
                if (pc_new >= cnt_q) begin
                    state_d = ERROR;
                    err_d   = ERR_PC;
                end else begin
                    init_pc_d = pc_new[ADDR_W-1:0];
                    state_d   = DATA;
                end
            end
            DATA: if (accept && (byte_idx == 2'd3)
                      && (32'(word_idx_q) == 32'(cnt_q) - 32'd1)) begin
                state_d = CKSUM;
            end
            CKSUM: if (accept) begin
                if (rx_data == csum_q) begin
                    state_d = RUN;
                end else begin
                    state_d = ERROR;
                    err_d   = ERR_CKSUM;
                end
            end
            RUN, ERROR: if (reload) begin
                state_d    = CNT_HI;
                err_d      = ERR_NONE;
                word_idx_d = '0;
                csum_d     = '0;
                asm_clear  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        rx_ready_d  = is_rx_state(state_d);
        proc_rst_d  = (state_d != RUN);
        load_done_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_ready_q  <= 1'b0;
            proc_rst_q  <= 1'b1;
            load_done_q <= 1'b0;
            err_q       <= ERR_NONE;
            cnt_q       <= '0;
            pc_hi_q     <= '0;
            csum_q      <= '0;
            init_pc_q   <= '0;
            word_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready_d;
            proc_rst_q  <= proc_rst_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            pc_hi_q     <= pc_hi_d;
            csum_q      <= csum_d;
            init_pc_q   <= init_pc_d;
            word_idx_q  <= word_idx_d;
        end
    end

    assign rx_ready            = rx_ready_q;
    assign instr_we            = word_valid;
    assign instr_feed          = word;
    assign instr_write_address = word_idx_q;
    assign init_pc             = init_pc_q;
    assign proc_rst            = proc_rst_q;
    assign load_done           = load_done_q;
    assign load_error          = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a frame-level model predicts writes and
// the final outcome; a negedge monitor checks every instruction-memory write.
module tb_program_loader;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned MAX_WORDS = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_ready;
    logic              reload = 1'b0;
    logic              instr_we;
    logic [31:0]       instr_feed;
    logic [ADDR_W-1:0] instr_write_address;
    logic [ADDR_W-1:0] init_pc;
    logic              proc_rst;
    logic              load_done;
    logic [1:0]        load_error;

    program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_valid            (rx_valid),
        .rx_data             (rx_data),
        .rx_ready            (rx_ready),
        .reload              (reload),
        .instr_we            (instr_we),
        .instr_feed          (instr_feed),
        .instr_write_address (instr_write_address),
        .init_pc             (init_pc),
        .proc_rst            (proc_rst),
        .load_done           (load_done),
        .load_error          (load_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    int          m_addr[$];
    logic [31:0] m_data[$];
    int          m_used;
    int          m_err;
    int          m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame-level model: parse the byte list directly into writes and an outcome.
    task automatic model(input logic [7:0] fr[$]);
        int cnt;
        logic [7:0] x;
        m_addr.delete();
        m_data.delete();
        cnt  = int'(fr[0]) * 256 + int'(fr[1]);
        m_pc = 0;
        if (cnt == 0 || cnt > int'(MAX_WORDS)) begin
            m_err = 1; m_used = 2; return;
        end
        m_pc = int'(fr[2]) * 256 + int'(fr[3]);
        if (m_pc >= cnt) begin
            m_err = 2; m_used = 4; return;
        end
        for (int w = 0; w < cnt; w++) begin
            m_addr.push_back(w);
            m_data.push_back({fr[4+4*w], fr[5+4*w], fr[6+4*w], fr[7+4*w]});
        end
        x = 8'h00;
        for (int i = 0; i < 4 + 4 * cnt; i++) x = x ^ fr[i];
        m_err  = (fr[4+4*cnt] == x) ? 0 : 3;
        m_used = 5 + 4 * cnt;
    endtask

    // Presents a byte at a negedge and returns once rx_ready confirms it will be taken.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] fr[$], input int gap);
        model(fr);
        foreach (m_addr[i]) begin
            exp_addr_q.push_back(m_addr[i]);
            exp_data_q.push_back(m_data[i]);
        end
        for (int i = 0; i < m_used; i++) begin
            send_byte(fr[i]);
            if (i == m_used - 1) begin
                check({name, "_prerel_proc_rst"}, proc_rst, 1);
                check({name, "_prerel_done"}, load_done, 0);
            end else begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    rx_valid = 1'b0;
                    rx_data  = 8'hEE;
                end
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check({name, "_proc_rst"}, proc_rst, (m_err != 0));
        check({name, "_load_done"}, load_done, (m_err == 0));
        check({name, "_load_error"}, load_error, m_err);
        check({name, "_rx_ready"}, rx_ready, 0);
        if (m_err == 0 || m_err == 3) check({name, "_init_pc"}, init_pc, m_pc);
        check({name, "_writes_left"}, exp_addr_q.size(), 0);
    endtask

    task automatic do_reload(input string name);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check({name, "_proc_rst"}, proc_rst, 1);
        check({name, "_load_done"}, load_done, 0);
        check({name, "_load_error"}, load_error, 0);
        check({name, "_rx_ready"}, rx_ready, 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (instr_we) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_we: got addr %0d data %h expected no write",
                             instr_write_address, instr_feed);
                end else begin
                    check("we_addr", instr_write_address, exp_addr_q.pop_front());
                    check("we_data", instr_feed, exp_data_q.pop_front());
                end
            end
            check("done_vs_proc_rst", load_done, !proc_rst);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] nominal[$];
        logic [7:0] badsum[$];
        logic [7:0] reload_fr[$];
        logic [7:0] cnt0[$];
        logic [7:0] cntbig[$];
        logic [7:0] badpc[$];
        nominal   = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h20, 8'h01, 8'h00, 8'h05,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h27};
        badsum    = nominal;
        badsum[12] = 8'h26;
        reload_fr = '{8'h00, 8'h01, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        cnt0      = '{8'h00, 8'h00};
        cntbig    = '{8'h04, 8'h01};
        badpc     = '{8'h00, 8'h02, 8'h00, 8'h02};

        // Pin the model against hand-derived values.
        model(nominal);
        check("model_nom_n", m_addr.size(), 2);
        check("model_nom_d0", m_data[0], 32'h20010005);
        check("model_nom_d1", m_data[1], 32'h00000000);
        check("model_nom_a1", m_addr[1], 1);
        check("model_nom_err", m_err, 0);
        check("model_nom_pc", m_pc, 1);
        model(badsum);
        check("model_bad_err", m_err, 3);
        model(reload_fr);
        check("model_rel_d0", m_data[0], 32'hAABBCCDD);

        #1 rst = 1'b1;
        #2;
        check("rst_rx_ready", rx_ready, 0);
        check("rst_we", instr_we, 0);
        check("rst_feed", instr_feed, 0);
        check("rst_addr", instr_write_address, 0);
        check("rst_init_pc", init_pc, 0);
        check("rst_proc_rst", proc_rst, 1);
        check("rst_done", load_done, 0);
        check("rst_err", load_error, 0);
        @(negedge clk);
        rst = 1'b0;
        check("idle_rx_ready", rx_ready, 0);
        @(negedge clk);
        check("cnthi_rx_ready", rx_ready, 1);

        run_frame("nominal", nominal, 0);
        check("nominal_init_pc_lit", init_pc, 1);

        do_reload("reload1");
        run_frame("badsum", badsum, 0);
        check("badsum_err_lit", load_error, 2'b11);

        do_reload("reload2");
        run_frame("cnt0", cnt0, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("cnt0_no_accept", rx_ready, 0);
            check("cnt0_err_hold", load_error, 2'b01);
        end
        rx_valid = 1'b0;

        do_reload("reload3");
        run_frame("cntbig", cntbig, 0);

        do_reload("reload4");
        run_frame("badpc", badpc, 0);
        check("badpc_err_lit", load_error, 2'b10);

        do_reload("reload5");
        run_frame("gapped", nominal, 3);

        do_reload("reload6");
        for (int i = 0; i < 6; i++) send_byte(nominal[i]);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_proc_rst", proc_rst, 1);
        check("midrst_we", instr_we, 0);
        check("midrst_done", load_done, 0);
        check("midrst_rx_ready", rx_ready, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_frame("after_rst", nominal, 0);

        do_reload("reload7");
        run_frame("reload_img", reload_fr, 0);
        check("reload_init_pc_lit", init_pc, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
